// File: rtl/add_sub_vector_checker.sv
// Stimulus driver and golden-model checker for the 8-bit add/subtract unit.
// Define ADD_SUB_LFSR_EN to append LFSR_VECTORS pseudo-random vectors after the directed table.
module add_sub_vector_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int LFSR_VECTORS  = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic       opcode,
    input  logic [7:0] dut_sum,
    input  logic       dut_carry,
    input  logic       dut_overflow,
    output logic       busy,
    output logic       done,
    output logic [7:0] pass_count,
    output logic [7:0] fail_count,
    output logic       first_fail_valid,
    output logic [7:0] first_fail_idx
);

    if (SETTLE_CYCLES < 0 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("SETTLE_CYCLES out of range 0..15");
    end
    if (LFSR_VECTORS < 1 || LFSR_VECTORS > 200) begin : g_bad_lfsr
        $error("LFSR_VECTORS out of range 1..200");
    end

`ifdef ADD_SUB_LFSR_EN
    localparam logic [7:0] LAST_IDX = 8'(15 + LFSR_VECTORS);
    localparam logic [16:0] LFSR_SEED = 17'h1ACE1;
    logic [16:0] lfsr;
`else
    localparam logic [7:0] LAST_IDX = 8'd15;
`endif
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;
    state_t state, next_state;

    logic [7:0] idx;
    logic [3:0] settle_cnt;

    // Directed vectors packed as {op, B, A}.
    function automatic logic [16:0] dir_vec(input logic [3:0] i);
        case (i)
            4'd0:  return {1'b0, 8'd100, 8'd100};
            4'd1:  return {1'b0, 8'd60,  8'd50};
            4'd2:  return {1'b0, 8'd200, 8'd200};
            4'd3:  return {1'b0, 8'd10,  8'd10};
            4'd4:  return {1'b0, 8'd2,   8'd1};
            4'd5:  return {1'b0, 8'd0,   8'd20};
            4'd6:  return {1'b0, 8'd0,   8'd0};
            4'd7:  return {1'b0, 8'd255, 8'd255};
            4'd8:  return {1'b0, 8'd200, 8'd20};
            4'd9:  return {1'b0, 8'd6,   8'd5};
            4'd10: return {1'b0, 8'd7,   8'd5};
            4'd11: return {1'b0, 8'd8,   8'd5};
            4'd12: return {1'b0, 8'd9,   8'd5};
            4'd13: return {1'b1, 8'd10,  8'd5};
            4'd14: return {1'b1, 8'd11,  8'd15};
            default: return {1'b1, 8'd1, 8'd128};
        endcase
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Golden model: subtract is A + ~B + 1, so carry=1 means no borrow.
    logic [7:0] b_eff;
    logic [8:0] gold_sum;
    logic       gold_ovf, match;
    always_comb begin
        b_eff    = opcode ? ~B : B;
        gold_sum = {1'b0, A} + {1'b0, b_eff} + {8'd0, opcode};
        gold_ovf = (A[7] == b_eff[7]) && (gold_sum[7] != A[7]);
        match    = (dut_sum == gold_sum[7:0]) && (dut_carry == gold_sum[8])
                   && (dut_overflow == gold_ovf);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (start) next_state = DRIVE;
            DRIVE:  next_state = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
            SETTLE: if (settle_cnt == SETTLE_LAST) next_state = CHECK;
            CHECK:  next_state = (idx == LAST_IDX) ? DONE : DRIVE;
            DONE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state == DRIVE) || (state == SETTLE) || (state == CHECK);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            A                <= '0;
            B                <= '0;
            opcode           <= 1'b0;
            idx              <= '0;
            settle_cnt       <= '0;
            pass_count       <= '0;
            fail_count       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
`ifdef ADD_SUB_LFSR_EN
            lfsr             <= LFSR_SEED;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    idx              <= '0;
                    pass_count       <= '0;
                    fail_count       <= '0;
                    first_fail_valid <= 1'b0;
                    first_fail_idx   <= '0;
`ifdef ADD_SUB_LFSR_EN
                    lfsr             <= LFSR_SEED;
`endif
                end
                DRIVE: begin
                    settle_cnt <= '0;
`ifdef ADD_SUB_LFSR_EN
                    if (idx > 8'd15) begin
                        {opcode, B, A} <= lfsr;
                        lfsr <= {lfsr[15:0], lfsr[16] ^ lfsr[13]};
                    end else
`endif
                    {opcode, B, A} <= dir_vec(idx[3:0]);
                end
                SETTLE: settle_cnt <= settle_cnt + 4'd1;
                CHECK: begin
                    if (match) pass_count <= sat_inc(pass_count);
                    else       fail_count <= sat_inc(fail_count);
                    if (!match && !first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_idx   <= idx;
                    end
                    if (idx != LAST_IDX) idx <= idx + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
